signature_misr: RTL and testbench

//  Downstream of the Compactor. Folds the Compactor's 6-bit com_res into a

---
 rtl/signature_misr_pkg.sv | 16 +
 rtl/signature_misr_step.sv | 16 +
 rtl/signature_misr.sv | 112 +++++++++++
 tb/tb_signature_misr.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/signature_misr_pkg.sv
// Shared definitions for the signature MISR: session FSM encoding and default
// polynomial/seed. MISR_W is the word width shared with the Compactor.
package signature_misr_pkg;

    localparam int MISR_W = 6;

    localparam logic [MISR_W-1:0] DEF_POLY = 6'h03;
    localparam logic [MISR_W-1:0] DEF_SEED = 6'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/signature_misr_step.sv
// One combinational MISR step: shift left, fold the MSB back through the
// feedback mask, then XOR in the incoming compacted word.
module misr_step
    import signature_misr_pkg::*;
#(
    parameter int             W    = MISR_W,
    parameter logic [W-1:0]   POLY = W'(DEF_POLY)
) (
    input  logic [W-1:0] sig_i,
    input  logic [W-1:0] com_res_i,
    output logic [W-1:0] sig_n_o
);

    assign sig_n_o = ({sig_i[W-2:0], 1'b0} ^ ({W{sig_i[W-1]}} & POLY)) ^ com_res_i;

endmodule

// File: rtl/signature_misr.sv
// Signature register over a session of NPAT compacted words, with a
// golden-value compare at session end and IDLE/RUN/DONE session control.
module signature_misr
    import signature_misr_pkg::*;
#(
    parameter int           W    = MISR_W,
    parameter int           NPAT = 16,
    parameter logic [W-1:0] POLY = W'(DEF_POLY),
    parameter logic [W-1:0] SEED = W'(DEF_SEED),
    parameter int           CW   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          com_valid,
    input  logic [W-1:0]  com_res,
    input  logic [W-1:0]  golden,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [W-1:0]  signature,
    output logic [CW-1:0] pat_cnt
);

    localparam logic [CW-1:0] LAST_CNT = CW'(NPAT - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  sig_q, sig_d, sig_n;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pass_q, pass_d;

    misr_step #(.W(W), .POLY(POLY)) u_step (
        .sig_i     (sig_q),
        .com_res_i (com_res),
        .sig_n_o   (sig_n)
    );

    always_comb begin
        // NOTE: every next-state variable holds its current value by default,
        // so no path through the case statement can infer a latch.
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;

        if (abort) begin
            state_d = IDLE;
            sig_d   = SEED;
            cnt_d   = '0;
            pass_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                        sig_d   = SEED;
                        cnt_d   = '0;
                    end
                end
                RUN: begin
                    // start is dropped here, including alongside the final word
                    if (com_valid) begin
                        sig_d = sig_n;
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == LAST_CNT) begin
                            state_d = DONE;
                            pass_d  = (sig_n == golden);
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        state_d = RUN;
                        sig_d   = SEED;
                        cnt_d   = '0;
                        pass_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    sig_d   = SEED;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign pass      = pass_q & done;
    assign signature = sig_q;
    assign pat_cnt   = cnt_q;

endmodule

// File: tb/tb_signature_misr.sv
// Directed bench for signature_misr: one NPAT=2 and one NPAT=16 instance
// driven from shared stimulus, with hand-computed and model-derived expectations.
module tb_signature_misr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, com_valid;
    logic [5:0] com_res, golden;

    logic       busy2, done2, pass2;
    logic [5:0] sig2;
    logic [7:0] cnt2;
    logic       busy16, done16, pass16;
    logic [5:0] sig16;
    logic [7:0] cnt16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    signature_misr #(.W(6), .NPAT(2), .POLY(6'h03), .SEED(6'h00), .CW(8)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .com_valid(com_valid), .com_res(com_res), .golden(golden),
        .busy(busy2), .done(done2), .pass(pass2), .signature(sig2), .pat_cnt(cnt2)
    );

    signature_misr #(.W(6), .NPAT(16), .POLY(6'h03), .SEED(6'h00), .CW(8)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .com_valid(com_valid), .com_res(com_res), .golden(golden),
        .busy(busy16), .done(done16), .pass(pass16), .signature(sig16), .pat_cnt(cnt16)
    );

    // Independent reference for x^6+x+1 with XOR-in of the input word.
    function automatic logic [5:0] ref_step(input logic [5:0] s, input logic [5:0] d);
        logic [5:0] t;
        t = s << 1;
        if (s[5]) t = t ^ 6'b000011;
        return t ^ d;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        start = 1'b0; abort = 1'b0; com_valid = 1'b0;
    endtask

    initial begin
        logic [5:0] exp_sig;
        int         n;
        logic       cv;
        logic [5:0] cr;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; com_valid = 1'b0;
        com_res = '0; golden = '0;
        repeat (3) cyc();
        check("rst_sig",  sig16, 6'h00);
        check("rst_busy", busy16, 1'b0);
        check("rst_done", done2, 1'b0);
        check("rst_cnt",  cnt2, 8'd0);
        rst_n = 1'b1;
        cyc();

        // NPAT=2, golden matches
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("t2_busy", busy2, 1'b1);
        check("t2_cnt0", cnt2, 8'd0);
        com_valid = 1'b1; com_res = 6'h22; golden = 6'h14;
        cyc();
        check("t2_sig1",   sig2, 6'h22);
        check("t2_cnt1",   cnt2, 8'd1);
        check("t2_done1",  done2, 1'b0);
        com_res = 6'h13;
        cyc();
        com_valid = 1'b0;
        check("t2_sig2",  sig2, 6'h14);
        check("t2_done",  done2, 1'b1);
        check("t2_pass",  pass2, 1'b1);
        check("t2_cnt2",  cnt2, 8'd2);
        check("t2_busy0", busy2, 1'b0);

        // Same stream, wrong golden; restart from DONE
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("t3_restart_done", done2, 1'b0);
        check("t3_restart_pass", pass2, 1'b0);
        check("t3_restart_sig",  sig2, 6'h00);
        check("t3_restart_cnt",  cnt2, 8'd0);
        com_valid = 1'b1; com_res = 6'h22; golden = 6'h15;
        cyc();
        com_res = 6'h13;
        cyc();
        check("t3_done", done2, 1'b1);
        check("t3_pass", pass2, 1'b0);
        check("t3_sig",  sig2, 6'h14);
        com_res = 6'h3f;
        cyc();
        com_valid = 1'b0;
        check("done_ignore_sig", sig2, 6'h14);
        check("done_ignore_cnt", cnt2, 8'd2);
        check("done_hold",       done2, 1'b1);

        // Abort: priority over start and com_valid, then IDLE ignores com_valid
        abort = 1'b1; start = 1'b1; com_valid = 1'b1;
        cyc();
        idle_inputs();
        check("abort_busy16", busy16, 1'b0);
        check("abort_done2",  done2, 1'b0);
        check("abort_pass2",  pass2, 1'b0);
        check("abort_sig2",   sig2, 6'h00);
        com_valid = 1'b1; com_res = 6'h2a;
        cyc();
        com_valid = 1'b0;
        check("idle_ignore_sig", sig16, 6'h00);
        check("idle_ignore_cnt", cnt16, 8'd0);

        // Three of sixteen, start in RUN ignored, then abort
        start = 1'b1;
        cyc();
        start = 1'b0;
        com_valid = 1'b1;
        com_res = 6'h01; cyc();
        com_res = 6'h02; cyc();
        com_res = 6'h03; cyc();
        com_valid = 1'b0;
        check("t5_sig3", sig16, 6'h03);
        check("t5_cnt3", cnt16, 8'd3);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("run_start_sig",  sig16, 6'h03);
        check("run_start_cnt",  cnt16, 8'd3);
        check("run_start_busy", busy16, 1'b1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("t5_abort_busy", busy16, 1'b0);
        check("t5_abort_cnt",  cnt16, 8'd0);
        check("t5_abort_sig",  sig16, 6'h00);

        // Sixteen zero words with gaps, golden zero
        start = 1'b1;
        cyc();
        start = 1'b0;
        golden = 6'h00; com_res = 6'h00;
        for (int i = 0; i < 16; i++) begin
            com_valid = 1'b1;
            cyc();
            com_valid = 1'b0;
            check($sformatf("t4_cnt%0d", i), cnt16, 32'(i + 1));
            check($sformatf("t4_done%0d", i), done16, (i == 15) ? 1'b1 : 1'b0);
            if (i[0]) cyc();
        end
        check("t4_sig",  sig16, 6'h00);
        check("t4_pass", pass16, 1'b1);
        com_valid = 1'b1;
        cyc();
        com_valid = 1'b0;
        check("t4_cnt_sat", cnt16, 8'd16);

        // Asynchronous reset mid-session, no clock edge required
        start = 1'b1;
        cyc();
        start = 1'b0;
        com_valid = 1'b1; com_res = 6'h2d;
        cyc();
        com_res = 6'h17;
        cyc();
        com_valid = 1'b0;
        check("t1_pre_busy", busy16, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t1_sig",  sig16, 6'h00);
        check("t1_busy", busy16, 1'b0);
        check("t1_done", done16, 1'b0);
        check("t1_pass", pass16, 1'b0);
        check("t1_cnt",  cnt16, 8'd0);
        cyc();
        rst_n = 1'b1;
        com_valid = 1'b1; com_res = 6'h11;
        cyc();
        com_valid = 1'b0;
        check("t1_need_start", busy16, 1'b0);
        check("t1_idle_sig",   sig16, 6'h00);

        // Random sessions checked every cycle against the reference
        for (int sess = 0; sess < 4; sess++) begin
            start = 1'b1;
            cyc();
            start = 1'b0;
            exp_sig = 6'h00;
            n = 0;
            while (n < 16) begin
                cv = ($urandom_range(0, 3) != 0);
                cr = 6'($urandom);
                com_valid = cv; com_res = cr;
                if (cv) begin
                    exp_sig = ref_step(exp_sig, cr);
                    n++;
                end
                golden = sess[0] ? exp_sig : ~exp_sig;
                cyc();
                check($sformatf("r%0d_sig", sess), sig16, exp_sig);
                check($sformatf("r%0d_cnt", sess), cnt16, 32'(n));
            end
            com_valid = 1'b0;
            check($sformatf("r%0d_done", sess), done16, 1'b1);
            check($sformatf("r%0d_pass", sess), pass16, sess[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
